sys_cmd_ctrl: RTL

SYS_CMD_CTRL -- requirements
Module: sys_cmd_ctrl

---
 rtl/sys_ctrl_pkg.sv | 26 ++
 rtl/sys_cmd_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl_pkg.sv
// rtl/sys_ctrl_pkg.sv - shared opcodes, FSM encoding and operand addresses for sys_cmd_ctrl
package sys_ctrl_pkg;

   localparam logic [7:0] OP_REG_WR   = 8'hAA;
   localparam logic [7:0] OP_REG_RD   = 8'hBB;
   localparam logic [7:0] OP_ALU_OPER = 8'hCC;
   localparam logic [7:0] OP_ALU_FUN  = 8'hDD;

   localparam int unsigned OPERAND_A_ADDR = 0;
   localparam int unsigned OPERAND_B_ADDR = 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_ADDR,
      S_WR_DATA,
      S_RD_ADDR,
      S_RD_WAIT,
      S_ALU_A,
      S_ALU_B,
      S_ALU_FUN,
      S_ALU_WAIT,
      S_SEND_LO,
      S_SEND_HI
   } ctrl_state_e;

endpackage

// File: rtl/sys_cmd_ctrl.sv
// rtl/sys_cmd_ctrl.sv - UART command decoder driving register file, ALU and TX FIFO
module sys_cmd_ctrl
   import sys_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int ALU_FUN_WIDTH = 4,
   parameter int ALU_OUT_WIDTH = 2 * DATA_WIDTH
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
   input  logic                     RX_D_VLD,
   input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
   input  logic                     ALU_OUT_VLD,
   output logic                     ALU_EN,
   output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
   output logic                     CLK_GATE_EN,
   output logic [ADDRESS_WIDTH-1:0] Address,
   output logic                     WrEn,
   output logic                     RdEn,
   output logic [DATA_WIDTH-1:0]    WrData,
   input  logic [DATA_WIDTH-1:0]    RdData,
   input  logic                     RdData_Valid,
   output logic [DATA_WIDTH-1:0]    TX_P_DATA,
   output logic                     TX_D_VLD,
   input  logic                     FIFO_FULL
);

   ctrl_state_e state_q, state_d;

   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0]    wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0]    tx_data_q, tx_data_d;
   logic [ALU_FUN_WIDTH-1:0] alu_fun_q, alu_fun_d;
   logic [ALU_OUT_WIDTH-1:0] result_q, result_d;
   logic                     wr_en_q, wr_en_d;
   logic                     rd_en_q, rd_en_d;
   logic                     tx_vld_q, tx_vld_d;
   logic                     is_alu_q, is_alu_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         tx_data_q <= '0;
         alu_fun_q <= '0;
         result_q  <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         tx_vld_q  <= 1'b0;
         is_alu_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         tx_data_q <= tx_data_d;
         alu_fun_q <= alu_fun_d;
         result_q  <= result_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         tx_vld_q  <= tx_vld_d;
         is_alu_q  <= is_alu_d;
      end
   end

   // Strobes default low so every WrEn/RdEn/TX_D_VLD is a single registered pulse.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      tx_data_d = tx_data_q;
      alu_fun_d = alu_fun_q;
      result_d  = result_q;
      is_alu_d  = is_alu_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      tx_vld_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  OP_REG_WR:   state_d = S_WR_ADDR;
                  OP_REG_RD:   state_d = S_RD_ADDR;
                  OP_ALU_OPER: state_d = S_ALU_A;
                  OP_ALU_FUN:  state_d = S_ALU_FUN;
                  default:     state_d = S_IDLE;
               endcase
            end
         end
         S_WR_ADDR: begin
            if (RX_D_VLD) begin
               wr_addr_d = RX_P_DATA[ADDRESS_WIDTH-1:0];
               state_d   = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               addr_d    = wr_addr_q;
               wr_data_d = RX_P_DATA;
               state_d   = S_IDLE;
            end
         end
         S_RD_ADDR: begin
            if (RX_D_VLD) begin
               rd_en_d = 1'b1;
               addr_d  = RX_P_DATA[ADDRESS_WIDTH-1:0];
               state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (RdData_Valid) begin
               result_d = ALU_OUT_WIDTH'(RdData);
               is_alu_d = 1'b0;
               state_d  = S_SEND_LO;
            end
         end
         S_ALU_A: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               addr_d    = ADDRESS_WIDTH'(OPERAND_A_ADDR);
               wr_data_d = RX_P_DATA;
               state_d   = S_ALU_B;
            end
         end
         S_ALU_B: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               addr_d    = ADDRESS_WIDTH'(OPERAND_B_ADDR);
               wr_data_d = RX_P_DATA;
               state_d   = S_ALU_FUN;
            end
         end
         S_ALU_FUN: begin
            if (RX_D_VLD) begin
               alu_fun_d = RX_P_DATA[ALU_FUN_WIDTH-1:0];
               state_d   = S_ALU_WAIT;
            end
         end
         S_ALU_WAIT: begin
            if (ALU_OUT_VLD) begin
               result_d = ALU_OUT;
               is_alu_d = 1'b1;
               state_d  = S_SEND_LO;
            end
         end
         S_SEND_LO: begin
            if (!FIFO_FULL) begin
               tx_vld_d  = 1'b1;
               tx_data_d = result_q[DATA_WIDTH-1:0];
               state_d   = is_alu_q ? S_SEND_HI : S_IDLE;
            end
         end
         S_SEND_HI: begin
            if (!FIFO_FULL) begin
               tx_vld_d  = 1'b1;
               tx_data_d = result_q[2*DATA_WIDTH-1:DATA_WIDTH];
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ALU clock stays gated on across the whole operand/function/wait span.
   assign ALU_EN      = (state_q == S_ALU_WAIT);
   assign CLK_GATE_EN = (state_q == S_ALU_A) || (state_q == S_ALU_B) ||
                        (state_q == S_ALU_FUN) || (state_q == S_ALU_WAIT);

   assign ALU_FUN   = alu_fun_q;
   assign Address   = addr_q;
   assign WrEn      = wr_en_q;
   assign RdEn      = rd_en_q;
   assign WrData    = wr_data_q;
   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;

endmodule
